fifo_channel_arbiter: RTL
=========================

FIFO_CHANNEL_ARBITER -- requirements
Module: fifo_channel_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of requesting channel FIFOs.
REQ-002 SHALL have parameter TIMEOUT, default 1023: mid-packet starvation limit in clk cycles.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have port ch_enable  in  NUM_CH  per-channel arbitration enable.
REQ-006 SHALL have port ch_data  in  NUM_CH*32  packed channel words; channel i at [32i+31:32i].
REQ-007 SHALL have port ch_valid  in  NUM_CH  per-channel word valid.
REQ-008 SHALL have port ch_last  in  NUM_CH  per-channel last word of packet.
REQ-009 SHALL have port ch_ready  out  NUM_CH  per-channel pop strobe.
REQ-010 SHALL have port fifo_data  out  32  word to downstream DAQ packer.
REQ-011 SHALL have port fifo_valid  out  1  downstream word valid.
REQ-012 SHALL have port fifo_last  out  1  downstream last word of packet.
REQ-013 SHALL have port fifo_ready  in  1  downstream accept.
REQ-014 SHALL have port grant  out  clog2(NUM_CH)  index of channel owning the output.
REQ-015 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-016 SHALL have port timeout_err  out  1  one-cycle pulse when an aborted packet's trailer word is accepted.
REQ-017 SHALL have port pkt_count  out  16  packets forwarded, including aborted ones.

Function
REQ-018 SHALL implement states IDLE, XFER, ABORT; a word transfers on a cycle with fifo_valid and fifo_ready both high.
REQ-019 IDLE SHALL drive fifo_valid=0 and ch_ready=0, and SHALL move to XFER on the first cycle any (ch_valid & ch_enable) bit is set.
REQ-020 In IDLE, SHALL register as grant the first requesting channel at or after rr_ptr, searching upward with wrap NUM_CH-1 -> 0.
REQ-021 The IDLE-to-XFER arbitration SHALL cost exactly one bubble cycle per packet.
REQ-022 XFER output path SHALL be combinational: fifo_data/valid/last = ch_data/valid/last[grant]; ch_ready[grant] = fifo_ready; all other ch_ready bits 0.
REQ-023 In XFER, accepting a word with ch_last[grant]=1 SHALL: set rr_ptr = (grant+1) mod NUM_CH, increment pkt_count, and return to IDLE.
REQ-024 Grant SHALL be held for the whole packet; deasserting ch_enable[grant] mid-packet SHALL have no effect until the packet ends.
REQ-025 In XFER, a 10-bit starve counter SHALL increment on every cycle with ch_valid[grant]=0 and clear on any cycle with it high.
REQ-026 When the starve counter reaches TIMEOUT, SHALL enter ABORT on the next cycle; no word is forwarded on that cycle.
REQ-027 ABORT SHALL drive fifo_valid=1, fifo_last=1, fifo_data = {16'hDEAD, 16'(grant)}, and ch_ready=0.
REQ-028 ABORT SHALL hold until fifo_ready, then: go to IDLE, pulse timeout_err, advance rr_ptr as REQ-023, increment pkt_count.
REQ-029 Words the aborted channel presents later SHALL be arbitrated as a new packet; no state is kept per channel.
REQ-030 pkt_count SHALL wrap 16'hFFFF -> 0; rr_ptr SHALL wrap NUM_CH-1 -> 0.
REQ-031 Two or more channels requesting in the same IDLE cycle SHALL be resolved solely by rr_ptr order.
REQ-032 fifo_valid SHALL NOT depend on fifo_ready, and any presented word SHALL be held stable until accepted.

Reset
REQ-033 rst_n low at a clk edge SHALL set state=IDLE, grant=0, rr_ptr=0, starve counter=0, pkt_count=0, timeout_err=0.
REQ-034 From the cycle after reset, fifo_valid, fifo_last, ch_ready and busy SHALL be 0 and fifo_data SHALL be 0.
REQ-035 Reset mid-packet SHALL drop the packet silently, with no trailer and no timeout_err.

Structure
REQ-036 A shared package SHALL hold the state encoding, the ABORT_MARKER constant 16'hDEAD and the NUM_CH default.
REQ-037 SHALL instantiate one combinational sub-module rr_pick (request vector, pointer -> index, found flag).

Verification
REQ-038 Single channel: ch1 sends 3 words 0x11,0x22,0x33 (last on 0x33) with fifo_ready=1 -> 1 bubble cycle, then 3 consecutive beats, grant=1, pkt_count=1.
REQ-039 Round-robin: all 4 channels continuously requesting 1-word packets -> grant sequence 0,1,2,3,0; rr_ptr wraps.
REQ-040 Backpressure: fifo_ready=0 for 5 cycles mid-packet -> fifo_data stable, no ch_ready pulse, no word lost or duplicated.
REQ-041 Starvation: ch2 stalls after one word with TIMEOUT=8 -> after 8 idle cycles, one word 0xDEAD0002 with fifo_last=1; timeout_err pulse; next grant goes to ch3 if it is requesting.
REQ-042 Disable plus reset: drop ch_enable[0] mid-packet -> packet completes; assert rst_n=0 during the next packet -> outputs 0 next cycle, pkt_count=0.

Source files
------------

// File: rtl/fifo_channel_arbiter_pkg.sv
// rtl/fifo_channel_arbiter_pkg.sv - shared state encoding and constants for the channel arbiter
package fifo_channel_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_t;

  localparam logic [15:0] ABORT_MARKER   = 16'hDEAD;
  localparam int          DEFAULT_NUM_CH = 4;

  // Channel index width; never zero so a single-channel build still has a grant bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_channel_arbiter_rr_pick.sv
// rtl/fifo_channel_arbiter_rr_pick.sv - first set request at or after a pointer, wrapping upward
module fifo_channel_arbiter_rr_pick
  import fifo_channel_arbiter_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int IDX_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // ptr < NUM_CH, so one conditional subtract is enough to wrap the sum.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_CH)) begin
        sum = sum - (IDX_W+1)'(NUM_CH);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_channel_arbiter.sv
// rtl/fifo_channel_arbiter.sv - packet-granular round-robin merge of channel FIFOs with starvation abort
module fifo_channel_arbiter
  import fifo_channel_arbiter_pkg::*;
#(
  parameter int NUM_CH  = DEFAULT_NUM_CH,
  parameter int TIMEOUT = 1023,
  localparam int GW     = idx_width(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    ch_enable,
  input  logic [NUM_CH*32-1:0] ch_data,
  input  logic [NUM_CH-1:0]    ch_valid,
  input  logic [NUM_CH-1:0]    ch_last,
  output logic [NUM_CH-1:0]    ch_ready,
  output logic [31:0]          fifo_data,
  output logic                 fifo_valid,
  output logic                 fifo_last,
  input  logic                 fifo_ready,
  output logic [GW-1:0]        grant,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [15:0]          pkt_count
);

  localparam logic [9:0]    STARVE_LIMIT = 10'(TIMEOUT);
  localparam logic [GW-1:0] LAST_CH      = GW'(NUM_CH - 1);

  arb_state_t    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [9:0]    starve_q, starve_d;
  logic [15:0]   pkt_count_q, pkt_count_d;
  logic          timeout_err_q, timeout_err_d;

  logic [NUM_CH-1:0] req;
  logic [GW-1:0]     pick_idx;
  logic              pick_found;
  logic [GW-1:0]     next_ptr;
  logic [31:0]       ch_word [NUM_CH];
  logic              sel_valid;
  logic              sel_last;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_word[g] = ch_data[32*g +: 32];
  end

  assign req       = ch_valid & ch_enable;
  assign sel_valid = ch_valid[grant_q];
  assign sel_last  = ch_last[grant_q];
  assign next_ptr  = (grant_q == LAST_CH) ? '0 : grant_q + GW'(1);

  fifo_channel_arbiter_rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (GW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    starve_d      = starve_q;
    pkt_count_d   = pkt_count_q;
    timeout_err_d = 1'b0;
    fifo_valid    = 1'b0;
    fifo_last     = 1'b0;
    fifo_data     = '0;
    ch_ready      = '0;
    case (state_q)
      ST_IDLE: begin
        starve_d = '0;
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        fifo_valid        = sel_valid;
        fifo_last         = sel_last;
        fifo_data         = ch_word[grant_q];
        ch_ready[grant_q] = fifo_ready;
        if (sel_valid) begin
          starve_d = '0;
          if (fifo_ready && sel_last) begin
            state_d     = ST_IDLE;
            rr_ptr_d    = next_ptr;
            pkt_count_d = pkt_count_q + 16'd1;
          end
        end else begin
          // The cycle that brings the dry run to the limit forwards nothing, so abort next.
          starve_d = starve_q + 10'd1;
          if (starve_d == STARVE_LIMIT) begin
            state_d = ST_ABORT;
          end
        end
      end
      ST_ABORT: begin
        fifo_valid = 1'b1;
        fifo_last  = 1'b1;
        fifo_data  = {ABORT_MARKER, 16'(grant_q)};
        if (fifo_ready) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
          rr_ptr_d      = next_ptr;
          pkt_count_d   = pkt_count_q + 16'd1;
          starve_d      = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      starve_q      <= '0;
      pkt_count_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      starve_q      <= starve_d;
      pkt_count_q   <= pkt_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = timeout_err_q;
  assign pkt_count   = pkt_count_q;

endmodule
